// File: rtl/mem_arbiter_if.sv
// Bus bundle between the cache controllers, the shared memory and mem_arbiter.
// master: the arbiter's view; slave: the caches/memory side.
interface mem_arbiter_if;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned WW = 3;

    logic          icache_req;
    logic [AW-1:0] icache_addr;
    logic          dcache_req;
    logic [AW-1:0] dcache_addr;
    logic          dwrite_req;
    logic [AW-1:0] dwrite_addr;
    logic [DW-1:0] dwrite_data;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_valid;
    logic [DW-1:0] fill_data;
    logic [WW-1:0] fill_word;
    logic          icache_fill_we;
    logic          dcache_fill_we;
    logic          icache_done;
    logic          dcache_done;
    logic          dwrite_ack;
    logic          busy;

    modport master (
        input  icache_req, icache_addr, dcache_req, dcache_addr,
        input  dwrite_req, dwrite_addr, dwrite_data, mem_rdata, mem_valid,
        output mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
        output icache_fill_we, dcache_fill_we, icache_done, dcache_done,
        output dwrite_ack, busy
    );

    modport slave (
        output icache_req, icache_addr, dcache_req, dcache_addr,
        output dwrite_req, dwrite_addr, dwrite_data, mem_rdata, mem_valid,
        input  mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
        input  icache_fill_we, dcache_fill_we, icache_done, dcache_done,
        input  dwrite_ack, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one pipelined memory between I-cache fills, D-cache fills and
// write-through stores; fills stream a whole block, stores are single writes.
module mem_arbiter (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
);
    localparam int unsigned WORDS = 8;
    localparam int unsigned CNT_W = $clog2(WORDS);
    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 16;
    localparam logic [AW-1:0] BLK_MASK = ~AW'(2 * WORDS - 1);

    typedef enum logic [1:0] {IDLE, WRITE, FILL} state_t;

    state_t           state, state_nx;
    logic             owner_d, owner_nx;
    logic [AW-1:0]    base, base_nx;
    logic [CNT_W-1:0] issue_cnt, issue_nx;
    logic             issue_all, issue_all_nx;
    logic [CNT_W-1:0] recv_cnt, recv_nx;
    logic [AW-1:0]    wr_addr, wr_addr_nx;
    logic [DW-1:0]    wr_data, wr_data_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            base      <= '0;
            issue_cnt <= '0;
            issue_all <= 1'b0;
            recv_cnt  <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            state     <= state_nx;
            owner_d   <= owner_nx;
            base      <= base_nx;
            issue_cnt <= issue_nx;
            issue_all <= issue_all_nx;
            recv_cnt  <= recv_nx;
            wr_addr   <= wr_addr_nx;
            wr_data   <= wr_data_nx;
        end
    end

    // Arbitration, memory issue and fill return handling.
    always_comb begin
        state_nx           = state;
        owner_nx           = owner_d;
        base_nx            = base;
        issue_nx           = issue_cnt;
        issue_all_nx       = issue_all;
        recv_nx            = recv_cnt;
        wr_addr_nx         = wr_addr;
        wr_data_nx         = wr_data;
        bus.mem_en         = 1'b0;
        bus.mem_wr         = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_wdata      = '0;
        bus.fill_data      = '0;
        bus.fill_word      = '0;
        bus.icache_fill_we = 1'b0;
        bus.dcache_fill_we = 1'b0;
        bus.icache_done    = 1'b0;
        bus.dcache_done    = 1'b0;
        bus.dwrite_ack     = 1'b0;
        bus.busy           = (state != IDLE);

        case (state)
            IDLE: begin
                if (bus.dwrite_req) begin
                    wr_addr_nx = bus.dwrite_addr;
                    wr_data_nx = bus.dwrite_data;
                    state_nx   = WRITE;
                end else if (bus.dcache_req || bus.icache_req) begin
                    owner_nx     = bus.dcache_req;
                    base_nx      = (bus.dcache_req ? bus.dcache_addr : bus.icache_addr) & BLK_MASK;
                    issue_nx     = '0;
                    issue_all_nx = 1'b0;
                    recv_nx      = '0;
                    state_nx     = FILL;
                end
            end
            WRITE: begin
                bus.mem_en     = 1'b1;
                bus.mem_wr     = 1'b1;
                bus.mem_addr   = wr_addr;
                bus.mem_wdata  = wr_data;
                bus.dwrite_ack = 1'b1;
                state_nx       = IDLE;
            end
            FILL: begin
                // Offset lives only in the low bits, so the block never carries out.
                if (!issue_all) begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = base | AW'({issue_cnt, 1'b0});
                    issue_nx     = issue_cnt + CNT_W'(1);
                    if (issue_cnt == CNT_W'(WORDS - 1)) issue_all_nx = 1'b1;
                end
                if (bus.mem_valid) begin
                    bus.fill_data      = bus.mem_rdata;
                    bus.fill_word      = recv_cnt;
                    bus.dcache_fill_we = owner_d;
                    bus.icache_fill_we = !owner_d;
                    recv_nx            = recv_cnt + CNT_W'(1);
                    if (recv_cnt == CNT_W'(WORDS - 1)) begin
                        bus.dcache_done = owner_d;
                        bus.icache_done = !owner_d;
                        state_nx        = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single shared, pipelined multi-cycle unified memory between the instruction-cache fill path, the data-cache fill path and data-cache write-through stores. It sits between the two cache controllers and the memory model. It replaces the per-stage single-cycle memories that currently feed the IF and MEM stages. Each fill streams an 8-word block into the owning cache, and each store performs one memory write.

## Interface
- WORDS, 8: 16-bit words per cache block. The issue and receive counters are log2(WORDS) bits wide.
- LAT, 4: memory read latency in cycles. Documentation only; the block is timed by mem_valid.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- icache_req  in  1  I-cache miss fill request; held high until icache_done.
- icache_addr  in  16  I-cache miss byte address.
- dcache_req  in  1  D-cache miss fill request; held high until dcache_done.
- dcache_addr  in  16  D-cache miss byte address.
- dwrite_req  in  1  store write-through request; held high until dwrite_ack.
- dwrite_addr  in  16  store byte address.
- dwrite_data  in  16  store data.
- mem_en  out  1  memory access enable.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  16  memory byte address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data.
- mem_valid  in  1  mem_rdata valid this cycle.
- fill_data  out  16  word being filled; equals mem_rdata.
- fill_word  out  3  word offset within the block for fill_data.
- icache_fill_we  out  1  write fill_data into the I-cache data array.
- dcache_fill_we  out  1  write fill_data into the D-cache data array.
- icache_done  out  1  one-cycle pulse: I-side fill complete.
- dcache_done  out  1  one-cycle pulse: D-side fill complete.
- dwrite_ack  out  1  one-cycle pulse: store issued to memory.
- busy  out  1  high in any state other than IDLE.

## Operation
- States are IDLE, WRITE and FILL.
- **IDLE:**
  - Grants by fixed priority: dwrite_req, then dcache_req, then icache_req.
  - On a write grant, latches dwrite_addr and dwrite_data and moves to WRITE.
  - On a fill grant, latches the owner (I or D) and base = {addr[15:4], 4'h0}, clears the issue and receive counters, and moves to FILL.
  - All memory outputs are 0 in IDLE.
- **WRITE (1 cycle):**
  - Drives mem_en=1, mem_wr=1, mem_addr and mem_wdata from the latched values.
  - Asserts dwrite_ack in the same cycle, then returns to IDLE.
- **FILL:**
  - While the issue counter is below WORDS, drives mem_en=1, mem_wr=0 and mem_addr = base + {issue_cnt, 1'b0}, and increments issue_cnt.
  - On each cycle with mem_valid: fill_data = mem_rdata, fill_word = recv_cnt, and the owner's fill_we is asserted; recv_cnt then increments.
  - On the return with recv_cnt = WORDS-1: the owner's done pulse is asserted in the same cycle, and the next state is IDLE.
- Address arithmetic is confined to bits [3:0]. Base 0xFFF0 issues 0xFFF0 through 0xFFFE with no carry out.
- Request inputs and addresses are ignored outside IDLE. A request dropped mid-fill does not abort the fill.
- mem_valid is ignored in IDLE and WRITE.
- Requester obligation: drop req in the cycle after its done or ack pulse unless a new miss or store is pending.

## Timing
- Reset value of every output is 0. State is IDLE and all counters are 0.
- rst_n low mid-operation immediately forces all outputs to 0 and the state to IDLE. The interrupted fill is lost; a still-held req restarts from word 0 after release.
- Grant latency: request seen in IDLE, then WRITE or the first FILL issue in the next cycle.
- Fill with memory latency LAT=4: issues in FILL cycles F0–F7, returns in F4–F11, done in F11, IDLE in F12.
  - Total from request to done: 13 cycles, including the IDLE arbitration cycle.
- Store: request in IDLE, then mem_wr and dwrite_ack in the next cycle, then IDLE again.
- Back-to-back grants: at least one IDLE cycle separates consecutive transactions.
- Returns may arrive with gaps. Completion counts mem_valid pulses only, never elapsed cycles.

## Test plan
1. icache_req=1 with icache_addr=0x1236, memory LAT=4.
   -> mem_addr steps 0x1230, 0x1232, … 0x123E over 8 cycles.
   -> icache_fill_we for words 0–7 with the data matching memory.
   -> icache_done 13 cycles after the request; dcache outputs stay 0.
2. icache_req and dcache_req raised in the same cycle.
   -> D block is filled first and dcache_done pulses.
   -> One IDLE cycle follows, then the I fill issues from word 0.
3. dwrite_req (0x0040, data 0xBEEF) and dcache_req (0x0040) raised together.
   -> One write cycle with mem_wr=1 and dwrite_ack.
   -> The fill then returns 0xBEEF at word 0.
4. rst_n pulsed low in FILL cycle F5 while dcache_req is held.
   -> All outputs drop to 0 asynchronously.
   -> After release, the fill reissues from base word 0 and dcache_done fires exactly once.
5. dcache_addr=0xFFFE, with the memory model inserting 2-cycle gaps between mem_valid pulses.
   -> Addresses are 0xFFF0–0xFFFE.
   -> fill_word runs 0–7 in order, and done pulses on the 8th valid only.
